duoseg_writer: RTL and testbench
================================

DUOSEG_WRITER -- requirements
Module: duoseg_writer

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW_SEG, default 1, meaning segment patterns are inverted (1 = segment off) before being written.
REQ-002 The block SHALL have parameter TARGET_ADDR, default 2'b00, meaning the slave word address of the digit-pair register.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_value  input  8  two hex digits to display: [3:0] right digit, [7:4] left digit.
REQ-006 The block SHALL have port in_valid  input  1  in_value is offered.
REQ-007 The block SHALL have port in_ready  output  1  block can accept in_value.
REQ-008 The block SHALL have ports m_address out 2, m_write out 1, m_read out 1, m_writedata out 16, m_byteenable out 2, forming the Avalon-MM master request.
REQ-009 The block SHALL have ports m_waitrequest in 1, m_readdata in 16, m_readdatavalid in 1, forming the Avalon-MM master response.
REQ-010 The block SHALL have port busy  output  1  transaction in progress.
REQ-011 The block SHALL have port mismatch  output  1  sticky readback-error flag.

Function
REQ-012 The block SHALL use states IDLE, WR, RD and RDWAIT; in_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in every other state.
REQ-013 A transfer SHALL be accepted on a rising edge with in_valid=1 and in_ready=1, and in_value SHALL be captured at that edge.
REQ-014 If the captured value equals the last written value and a last value exists, the block SHALL stay in IDLE and issue no transaction.
REQ-015 Otherwise the next state SHALL be WR, so that m_write is asserted the cycle after acceptance.
REQ-016 The write data SHALL be m_writedata[6:0]=seg(in_value[3:0]), [14:8]=seg(in_value[7:4]), with bits 7 and 15 equal to 0; m_byteenable SHALL be 2'b11 and m_address SHALL be TARGET_ADDR.
REQ-017 In WR, m_write, m_address, m_writedata and m_byteenable SHALL be held stable while m_waitrequest=1.
REQ-018 The write SHALL complete on the edge where m_write=1 and m_waitrequest=0; the last value SHALL update then, and the next state SHALL be IDLE, or RD with READBACK_EN.
REQ-019 seg() SHALL map hex to segments with bit0=a through bit6=g, active-high: 0->0x3F, 1->0x06, 8->0x7F, A->0x77, F->0x71, all 16 codes standard.
REQ-020 When ACTIVE_LOW_SEG=1, seg() SHALL be the bitwise inverse of that table, e.g. 0->0x40 and 8->0x00.
REQ-021 m_write and m_read SHALL never both be 1, and no request SHALL be asserted in IDLE or RDWAIT.
REQ-022 in_valid while busy SHALL be ignored; the source holds the value until in_ready.

Reset
REQ-023 While reset_n=0, all state SHALL clear asynchronously: state=IDLE, in_ready=1 after release, m_write=m_read=0, m_address=0, m_writedata=0, m_byteenable=0, busy=0, mismatch=0, last-value-valid=0.
REQ-024 A reset during WR or RD SHALL abandon the transaction without retry, and the first accepted value after reset SHALL always be written.

Configuration
REQ-025 Macro DUOSEG_READBACK_EN SHALL, when defined, enable the RD and RDWAIT states.
REQ-026 With DUOSEG_READBACK_EN, after the write the block SHALL hold m_read at TARGET_ADDR with byteenable 2'b11 until m_waitrequest=0, then wait in RDWAIT for m_readdatavalid=1.
REQ-027 With DUOSEG_READBACK_EN, the block SHALL compare m_readdata[14:8] and [6:0] to the written pattern, set mismatch on any difference (cleared only by reset), and then return to IDLE.
REQ-028 Without DUOSEG_READBACK_EN, the RD and RDWAIT states SHALL be absent, m_read SHALL be tied 0, mismatch SHALL be tied 0, and WR SHALL always return to IDLE.

Structure
REQ-029 Package duoseg_pkg SHALL hold the state enum, the 16-entry active-high segment table constant and the default target address.
REQ-030 Sub-module hex_to_seg7 (4-bit in, 7-bit out, parameter ACTIVE_LOW_SEG) SHALL be instantiated twice.

Verification
REQ-031 Bench SHALL cover: reset, then in_value=0x18 with waitrequest=0 and ACTIVE_LOW_SEG=1 -> one m_write next cycle, writedata=0x7900, in_ready back to 1 the cycle after.
REQ-032 Bench SHALL cover: in_value=0xAF with waitrequest held 3 cycles -> m_write high 4 cycles, writedata=0x080E stable throughout.
REQ-033 Bench SHALL cover: 0x18 accepted twice consecutively -> exactly one write; then 0x19 -> second write, writedata=0x7910.
REQ-034 Bench SHALL cover: reset_n asserted mid-WR -> m_write drops without a clock edge; 0x18 after release -> written, not suppressed.
REQ-035 Bench SHALL cover, with DUOSEG_READBACK_EN: write 0x18, readdata returned 0x7900 -> mismatch=0; write 0x00, readdata 0x4041 -> mismatch=1 and stays 1.
REQ-036 Bench SHALL cover: ACTIVE_LOW_SEG=0 with in_value=0x80 -> writedata=0x7F3F.

Source files
------------

// File: rtl/duoseg_pkg.sv
// Shared types and constants for the two-digit seven-segment bus writer.
// DUOSEG_READBACK_EN adds the readback states to the state enum.
package duoseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR
`ifdef DUOSEG_READBACK_EN
    ,
    RD,
    RDWAIT
`endif
  } state_t;

  localparam logic [1:0] DEFAULT_TARGET_ADDR = 2'b00;

  // Active-high patterns, bit0 = segment a ... bit6 = segment g, index = hex digit.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to seven-segment pattern, optionally inverted for
// common-anode displays.
module hex_to_seg7
  import duoseg_pkg::*;
#(
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  logic [6:0] seg_high;

  assign seg_high = seg_lookup(hex);
  assign seg      = ACTIVE_LOW_SEG ? ~seg_high : seg_high;

endmodule

// File: rtl/duoseg_writer.sv
// Writes a two-digit segment pattern to an Avalon-MM slave register, skipping
// repeats. DUOSEG_READBACK_EN adds a read-back check with a sticky mismatch flag.
module duoseg_writer
  import duoseg_pkg::*;
#(
  parameter bit         ACTIVE_LOW_SEG = 1'b1,
  parameter logic [1:0] TARGET_ADDR    = DEFAULT_TARGET_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic        m_read,
  output logic [15:0] m_writedata,
  output logic [1:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [15:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        mismatch
);

  state_t      state_reg;
  logic [7:0]  value_reg;
  logic [7:0]  last_reg;
  logic        last_valid_reg;
  logic        write_reg;
  logic [1:0]  address_reg;
  logic [15:0] writedata_reg;
  logic [1:0]  byteenable_reg;
  logic [6:0]  seg_lo;
  logic [6:0]  seg_hi;
  logic        is_repeat;

  hex_to_seg7 #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_seg_lo (
    .hex (in_value[3:0]),
    .seg (seg_lo)
  );

  hex_to_seg7 #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_seg_hi (
    .hex (in_value[7:4]),
    .seg (seg_hi)
  );

  assign is_repeat = last_valid_reg && (in_value == last_reg);

`ifdef DUOSEG_READBACK_EN
  logic read_reg;
  logic mismatch_reg;
  logic unused_rsp_bits;

  // Bits 7 and 15 carry no segment and are not checked.
  assign unused_rsp_bits = m_readdata[15] ^ m_readdata[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      value_reg      <= 8'h00;
      last_reg       <= 8'h00;
      last_valid_reg <= 1'b0;
      write_reg      <= 1'b0;
      read_reg       <= 1'b0;
      address_reg    <= 2'b00;
      writedata_reg  <= 16'h0000;
      byteenable_reg <= 2'b00;
      mismatch_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && !is_repeat) begin
            state_reg      <= WR;
            value_reg      <= in_value;
            write_reg      <= 1'b1;
            address_reg    <= TARGET_ADDR;
            byteenable_reg <= 2'b11;
            writedata_reg  <= {1'b0, seg_hi, 1'b0, seg_lo};
          end
        end
        WR: begin
          if (!m_waitrequest) begin
            write_reg      <= 1'b0;
            read_reg       <= 1'b1;
            last_reg       <= value_reg;
            last_valid_reg <= 1'b1;
            state_reg      <= RD;
          end
        end
        RD: begin
          if (!m_waitrequest) begin
            read_reg  <= 1'b0;
            state_reg <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (m_readdatavalid) begin
            if ((m_readdata[14:8] != writedata_reg[14:8]) ||
                (m_readdata[6:0] != writedata_reg[6:0])) begin
              mismatch_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_read   = read_reg;
  assign mismatch = mismatch_reg;
`else
  logic unused_rsp_bits;

  assign unused_rsp_bits = ^{m_readdata, m_readdatavalid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      value_reg      <= 8'h00;
      last_reg       <= 8'h00;
      last_valid_reg <= 1'b0;
      write_reg      <= 1'b0;
      address_reg    <= 2'b00;
      writedata_reg  <= 16'h0000;
      byteenable_reg <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && !is_repeat) begin
            state_reg      <= WR;
            value_reg      <= in_value;
            write_reg      <= 1'b1;
            address_reg    <= TARGET_ADDR;
            byteenable_reg <= 2'b11;
            writedata_reg  <= {1'b0, seg_hi, 1'b0, seg_lo};
          end
        end
        WR: begin
          if (!m_waitrequest) begin
            write_reg      <= 1'b0;
            last_reg       <= value_reg;
            last_valid_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_read   = 1'b0;
  assign mismatch = 1'b0;
`endif

  assign in_ready     = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign m_write      = write_reg;
  assign m_address    = address_reg;
  assign m_writedata  = writedata_reg;
  assign m_byteenable = byteenable_reg;

endmodule

// File: tb/tb_duoseg_writer.sv
// Bench for duoseg_writer: two instances (inverted and active-high segments)
// checked every cycle against a transaction-level model, plus literal checks.
module tb_duoseg_writer;

`ifdef DUOSEG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [1:0] ADDR_B = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_value = 8'h00;
  logic        in_valid = 1'b0;
  logic        m_waitrequest = 1'b0;
  logic [15:0] m_readdata = 16'h0000;
  logic        m_readdatavalid = 1'b0;

  logic        in_ready_a, m_write_a, m_read_a, busy_a, mismatch_a;
  logic [1:0]  m_address_a, m_byteenable_a;
  logic [15:0] m_writedata_a;
  logic        in_ready_b, m_write_b, m_read_b, busy_b, mismatch_b;
  logic [1:0]  m_address_b, m_byteenable_b;
  logic [15:0] m_writedata_b;

  always #5 clk = ~clk;

  duoseg_writer dut_a (
    .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready_a), .m_address(m_address_a), .m_write(m_write_a),
    .m_read(m_read_a), .m_writedata(m_writedata_a), .m_byteenable(m_byteenable_a),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .busy(busy_a), .mismatch(mismatch_a)
  );

  duoseg_writer #(.ACTIVE_LOW_SEG(1'b0), .TARGET_ADDR(ADDR_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready_b), .m_address(m_address_b), .m_write(m_write_b),
    .m_read(m_read_b), .m_writedata(m_writedata_b), .m_byteenable(m_byteenable_b),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .busy(busy_b), .mismatch(mismatch_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [15:0] pattern(input logic [7:0] v, input bit low);
    logic [6:0] lo, hi;
    lo = seg_tab[v[3:0]];
    hi = seg_tab[v[7:4]];
    if (low) begin
      lo = ~lo;
      hi = ~hi;
    end
    return {1'b0, hi, 1'b0, lo};
  endfunction

  // ph: 0 nothing pending, 1 write on the bus, 2 read on the bus, 3 awaiting read data
  int          ph = 0;
  logic [7:0]  pend_val = 8'h00, last_val = 8'h00;
  bit          have_last = 1'b0;
  logic [15:0] e_wd_a = 16'h0, e_wd_b = 16'h0;
  logic [1:0]  e_addr_a = 2'b0, e_addr_b = 2'b0, e_be = 2'b0;
  bit          e_mis_a = 1'b0, e_mis_b = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0; have_last = 1'b0;
      e_wd_a = 16'h0; e_wd_b = 16'h0; e_addr_a = 2'b0; e_addr_b = 2'b0; e_be = 2'b0;
      e_mis_a = 1'b0; e_mis_b = 1'b0;
    end else begin
      case (ph)
        0: if (in_valid && !(have_last && in_value == last_val)) begin
             ph = 1; pend_val = in_value;
             e_wd_a = pattern(in_value, 1'b1); e_wd_b = pattern(in_value, 1'b0);
             e_addr_a = 2'b00; e_addr_b = ADDR_B; e_be = 2'b11;
           end
        1: if (!m_waitrequest) begin
             last_val = pend_val; have_last = 1'b1;
             ph = RB ? 2 : 0;
           end
        2: if (!m_waitrequest) ph = 3;
        3: if (m_readdatavalid) begin
             if ((m_readdata & 16'h7F7F) != e_wd_a) e_mis_a = 1'b1;
             if ((m_readdata & 16'h7F7F) != e_wd_b) e_mis_b = 1'b1;
             ph = 0;
           end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("ready_a", in_ready_a, ph == 0);
    chk("busy_a", busy_a, ph != 0);
    chk("write_a", m_write_a, ph == 1);
    chk("read_a", m_read_a, ph == 2);
    chk("mis_a", mismatch_a, e_mis_a);
    chk("ready_b", in_ready_b, ph == 0);
    chk("write_b", m_write_b, ph == 1);
    chk("read_b", m_read_b, ph == 2);
    chk("mis_b", mismatch_b, e_mis_b);
    if (ph == 1 || !reset_n) begin
      chk("wdata_a", m_writedata_a, e_wd_a);
      chk("wdata_b", m_writedata_b, e_wd_b);
    end
    if (ph == 1 || ph == 2 || !reset_n) begin
      chk("addr_a", m_address_a, e_addr_a);
      chk("addr_b", m_address_b, e_addr_b);
      chk("be_a", m_byteenable_a, e_be);
      chk("be_b", m_byteenable_b, e_be);
    end
  end

  // Count completed writes seen on the bus of instance A.
  int dut_wr = 0;
  always @(posedge clk)
    if (reset_n && m_write_a && !m_waitrequest) dut_wr++;

  // Slave read responder: one cycle after the read is accepted, return data.
  bit          rb_force = 1'b0;
  bit          rb_random = 1'b0;
  logic [15:0] rb_value = 16'h0;
  always @(posedge clk) begin
    if (reset_n && m_read_a && !m_waitrequest) begin
      #1;
      if (rb_force) m_readdata = rb_value;
      else begin
        m_readdata = e_wd_a;
        if (rb_random) begin
          case ($urandom_range(0, 7))
            0: m_readdata = m_readdata ^ 16'h0100;
            1: m_readdata = m_readdata ^ 16'h8080;
            default: ;
          endcase
        end
      end
      m_readdatavalid = 1'b1;
      @(posedge clk);
      #1 m_readdatavalid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready_a && n < 40) begin
      cyc();
      n++;
    end
    chk("idle_timeout", in_ready_a, 1);
  endtask

  task automatic offer(input logic [7:0] v);
    in_value = v;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int hi;
    int w0;
    #2;
    chk("rst_write", m_write_a, 0);
    chk("rst_wdata", m_writedata_a, 16'h0000);
    chk("rst_busy", busy_a, 0);
    chk("rst_mis", mismatch_a, 0);
    cyc();
    cyc();
    reset_n = 1'b1;

    // first write, no wait states
    m_waitrequest = 1'b0;
    offer(8'h18);
    chk("s1_write", m_write_a, 1);
    chk("s1_wd_a", m_writedata_a, 16'h7900);
    chk("s1_wd_b", m_writedata_b, 16'h067F);
    chk("s1_addr_b", m_address_b, ADDR_B);
    chk("s1_be", m_byteenable_a, 2'b11);
    cyc();
    chk("s1_write_off", m_write_a, 0);
    if (RB) chk("s1_read", m_read_a, 1);
    else    chk("s1_ready", in_ready_a, 1);
    wait_idle();

    // write held by waitrequest for three cycles
    m_waitrequest = 1'b1;
    in_value = 8'hAF;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_write_a) hi++;
      chk("s2_wd", m_writedata_a, 16'h080E);
      if (i == 3) m_waitrequest = 1'b0;
      cyc();
    end
    chk("s2_hi_cycles", hi, 4);
    chk("s2_done", m_write_a, 0);
    wait_idle();

    // repeat suppression
    w0 = dut_wr;
    offer(8'h18);
    wait_idle();
    offer(8'h18);
    chk("s3_suppr_write", m_write_a, 0);
    chk("s3_suppr_ready", in_ready_a, 1);
    wait_idle();
    chk("s3_one_write", dut_wr - w0, 1);
    offer(8'h19);
    chk("s3_wd", m_writedata_a, 16'h7910);
    wait_idle();
    chk("s3_two_writes", dut_wr - w0, 2);

    // asynchronous reset during a stalled write
    m_waitrequest = 1'b1;
    offer(8'h25);
    chk("s4_write", m_write_a, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("s4_async_drop", m_write_a, 0);
    chk("s4_busy", busy_a, 0);
    cyc();
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    offer(8'h18);
    chk("s4_rewrite", m_write_a, 1);
    chk("s4_wd", m_writedata_a, 16'h7900);
    wait_idle();

    // active-high instance pattern
    offer(8'h80);
    chk("s6_wd_b", m_writedata_b, 16'h7F3F);
    chk("s6_wd_a", m_writedata_a, 16'h0040);
    wait_idle();

    // randomized traffic
    rb_random = 1'b1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      m_waitrequest = ($urandom_range(0, 2) == 0);
      if (!(in_valid && !in_ready_a)) begin
        in_valid = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 3))
          0: in_value = 8'h18;
          1: in_value = 8'h19;
          default: in_value = 8'($urandom_range(0, 255));
        endcase
      end
      cyc();
    end
    in_valid = 1'b0;
    m_waitrequest = 1'b0;
    rb_random = 1'b0;
    wait_idle();

`ifdef DUOSEG_READBACK_EN
    rb_force = 1'b1;
    do_reset();
    rb_value = 16'h7900;
    offer(8'h18);
    wait_idle();
    chk("s5_mis_clean", mismatch_a, 0);
    rb_value = 16'h4041;
    offer(8'h00);
    wait_idle();
    chk("s5_mis_set", mismatch_a, 1);
    rb_value = 16'h7900;
    offer(8'h18);
    wait_idle();
    repeat (3) cyc();
    chk("s5_mis_sticky", mismatch_a, 1);
    rb_force = 1'b0;
`else
    chk("s5_no_mis", mismatch_a, 0);
    chk("s5_no_read", m_read_a, 0);
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
